// File: rtl/cpu_clk_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_clk_ctrl
//
// Run / stop / single-step controller for the soft CPU clock. The board clock
// is divided down to a slow CPU clock that is always registered and free of
// glitches. That clock runs freely, parks low, or produces exactly one full
// period for each debounced press of the step key.
//
// Parameters
//   DIV : board-clock cycles per CPU clock half-period (>= 2)
//   DB  : cycles the synchronised step key must be stable before a level
//         change is accepted (>= 2)
//
// Ports
//   iCLK     : board clock, the only clock domain
//   iRST_N   : asynchronous active-low reset; the clock parks low
//   iRUN     : run switch, asynchronous level (1 = free-run)
//   iSTEP_N  : step push-button, asynchronous, active-low, bouncy
//   oCPU_CLK : divided CPU clock, registered
//   oTICK    : one-cycle pulse in the cycle where oCPU_CLK goes 0->1
//   oSTATE   : 0 = STOPPED, 1 = RUN, 2 = STEP
//   oCYCLES  : count of oCPU_CLK rising edges since reset (wraps)
// ---------------------------------------------------------------------------
module cpu_clk_ctrl #(
    parameter int DIV = 250000,
    parameter int DB  = 500000
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iRUN,
    input  logic        iSTEP_N,
    output logic        oCPU_CLK,
    output logic        oTICK,
    output logic [1:0]  oSTATE,
    output logic [15:0] oCYCLES
);

    localparam int CW  = $clog2(DIV);
    localparam int DBW = $clog2(DB);

    localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DB - 1);

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUN     = 2'd1,
        ST_STEP    = 2'd2
    } state_t;

    // Synchronisers
    logic run_meta_q,  run_meta_d;
    logic run_s_q,     run_s_d;
    logic step_meta_q, step_meta_d;
    logic step_s_q,    step_s_d;

    // Debounce and press detect
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic           key_db_q, key_db_d;
    logic           key_db_dly_q, key_db_dly_d;
    logic           press_q, press_d;

    // Prescaler, state machine and outputs
    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           cpu_clk_q, cpu_clk_d;
    logic           tick_q, tick_d;
    logic [15:0]    cycles_q, cycles_d;
    logic           cnt_last;

    // Two-flop synchronisers. The step synchroniser idles high so that a
    // key at rest never looks like a press coming out of reset.
    always_comb begin
        run_meta_d  = iRUN;
        run_s_d     = run_meta_q;
        step_meta_d = iSTEP_N;
        step_s_d    = step_meta_q;
    end

    // Debounce: the counter measures how long step_s has disagreed with
    // the accepted level. Any agreement restarts it, so only a run of DB
    // consecutive disagreeing cycles moves key_db.
    always_comb begin
        key_db_d = key_db_q;
        db_cnt_d = '0;
        if (step_s_q != key_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                key_db_d = step_s_q;
            end else begin
                db_cnt_d = db_cnt_q + DBW'(1);
            end
        end
    end

    // Press is registered from a delayed copy of key_db, so it appears one
    // cycle after key_db falls and lasts exactly one cycle.
    always_comb begin
        key_db_dly_d = key_db_q;
        press_d      = key_db_dly_q & ~key_db_q;
    end

    assign cnt_last = (cnt_q == CNT_LAST);

    // State machine and prescaler. Every exit from an active state occurs
    // on a prescaler wrap. That keeps every CPU clock phase a full DIV cycles
    // long. RUN leaves only where a rise would occur, so the rise is simply
    // not made. STEP leaves on its own falling edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cpu_clk_d = cpu_clk_q;
        tick_d    = 1'b0;

        case (state_q)
            ST_STOPPED: begin
                cnt_d     = '0;
                cpu_clk_d = 1'b0;
                // Run has priority. A press seen in the same cycle is lost.
                if (run_s_q) begin
                    state_d = ST_RUN;
                end else if (press_q) begin
                    state_d = ST_STEP;
                end
            end

            ST_RUN: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (!cpu_clk_q && !run_s_q) begin
                        state_d = ST_STOPPED;
                    end else begin
                        cpu_clk_d = ~cpu_clk_q;
                        tick_d    = ~cpu_clk_q;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_STEP: begin
                if (cnt_last) begin
                    cnt_d     = '0;
                    cpu_clk_d = ~cpu_clk_q;
                    tick_d    = ~cpu_clk_q;
                    if (cpu_clk_q) begin
                        state_d = ST_STOPPED;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d   = ST_STOPPED;
                cnt_d     = '0;
                cpu_clk_d = 1'b0;
            end
        endcase
    end

    // The cycle counter advances in the same cycle as the tick it counts,
    // so oCYCLES already includes a rise while oTICK is high for that rise.
    always_comb begin
        cycles_d = cycles_q;
        if (tick_d) begin
            cycles_d = cycles_q + 16'd1;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            run_meta_q   <= 1'b0;
            run_s_q      <= 1'b0;
            step_meta_q  <= 1'b1;
            step_s_q     <= 1'b1;
            db_cnt_q     <= '0;
            key_db_q     <= 1'b1;
            key_db_dly_q <= 1'b1;
            press_q      <= 1'b0;
            state_q      <= ST_STOPPED;
            cnt_q        <= '0;
            cpu_clk_q    <= 1'b0;
            tick_q       <= 1'b0;
            cycles_q     <= '0;
        end else begin
            run_meta_q   <= run_meta_d;
            run_s_q      <= run_s_d;
            step_meta_q  <= step_meta_d;
            step_s_q     <= step_s_d;
            db_cnt_q     <= db_cnt_d;
            key_db_q     <= key_db_d;
            key_db_dly_q <= key_db_dly_d;
            press_q      <= press_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cpu_clk_q    <= cpu_clk_d;
            tick_q       <= tick_d;
            cycles_q     <= cycles_d;
        end
    end

    assign oCPU_CLK = cpu_clk_q;
    assign oTICK    = tick_q;
    assign oSTATE   = state_q;
    assign oCYCLES  = cycles_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_clk_ctrl
//
// Directed bench for cpu_clk_ctrl with DIV=4 and DB=3. Inputs change 1 ns
// after a rising edge. Outputs are sampled at the same point. "Edge n" in
// the comments is the n-th rising edge after the stimulus of a step is
// applied. Expected values are worked out by hand from the intended timing.
// ---------------------------------------------------------------------------
module tb_cpu_clk_ctrl;

    logic        iCLK;
    logic        iRST_N;
    logic        iRUN;
    logic        iSTEP_N;
    logic        oCPU_CLK;
    logic        oTICK;
    logic [1:0]  oSTATE;
    logic [15:0] oCYCLES;

    int compared;
    int mismatched;

    int   badIdle;
    int   rises;
    int   highCycles;
    int   stepCycles;
    int   runCycles;
    logic prevClk;
    logic [1:0] stObs  [0:40];
    logic       clkObs [0:40];

    cpu_clk_ctrl #(
        .DIV (4),
        .DB  (3)
    ) dut (
        .iCLK     (iCLK),
        .iRST_N   (iRST_N),
        .iRUN     (iRUN),
        .iSTEP_N  (iSTEP_N),
        .oCPU_CLK (oCPU_CLK),
        .oTICK    (oTICK),
        .oSTATE   (oSTATE),
        .oCYCLES  (oCYCLES)
    );

    // 10 ns board clock
    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Guard against a run that never reaches its summary
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    task automatic applyStimulus(input logic run, input logic stepN);
        iRUN    = run;
        iSTEP_N = stepN;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive iSTEP_N/iRUN per cycle and record what the DUT shows after each
    // edge. Index j of the arrays holds the outputs sampled after edge j.
    task automatic runPattern(input int n, input int mode);
        logic runV;
        logic stepV;
        rises      = 0;
        highCycles = 0;
        stepCycles = 0;
        runCycles  = 0;
        prevClk    = oCPU_CLK;
        for (int i = 0; i < n; i++) begin
            runV  = 1'b0;
            stepV = 1'b1;
            case (mode)
                0: stepV = (i == 1) || (i >= 10);
                1: stepV = ((i >= 3) && (i <= 5)) || (i >= 20);
                2: stepV = (i >= 2);
                default: begin
                    stepV = (i >= 12);
                    runV  = (i >= 4);
                end
            endcase
            applyStimulus(runV, stepV);
            waitCycles(1);
            if (oCPU_CLK && !prevClk) rises++;
            if (oCPU_CLK) highCycles++;
            if (oSTATE == 2'd2) stepCycles++;
            if (oSTATE == 2'd1) runCycles++;
            prevClk = oCPU_CLK;
            if (i + 1 <= 40) begin
                stObs[i + 1]  = oSTATE;
                clkObs[i + 1] = oCPU_CLK;
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        iRST_N     = 1'b0;
        applyStimulus(1'b0, 1'b1);

        // Reset is held while the inputs toggle. Nothing must move.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(logic'(i % 2), logic'((i + 1) % 2));
            waitCycles(1);
            checkOutput("rst_clk",    {31'd0, oCPU_CLK}, 32'd0);
            checkOutput("rst_state",  {30'd0, oSTATE},   32'd0);
            checkOutput("rst_cycles", {16'd0, oCYCLES},  32'd0);
        end
        checkOutput("rst_tick", {31'd0, oTICK}, 32'd0);

        applyStimulus(1'b0, 1'b1);
        iRST_N  = 1'b1;
        badIdle = 0;
        for (int i = 0; i < 50; i++) begin
            waitCycles(1);
            if (oCPU_CLK !== 1'b0 || oSTATE !== 2'd0) badIdle++;
        end
        checkOutput("idle_no_toggle", badIdle,           32'd0);
        checkOutput("idle_cycles",    {16'd0, oCYCLES},  32'd0);

        // Free-run: RUN at edge 3, first rise at edge 7, then every 8
        applyStimulus(1'b1, 1'b1);
        waitCycles(2);
        checkOutput("run_state_e2", {30'd0, oSTATE}, 32'd0);
        waitCycles(1);
        checkOutput("run_state_e3", {30'd0, oSTATE}, 32'd1);
        waitCycles(3);
        checkOutput("run_clk_e6",   {31'd0, oCPU_CLK}, 32'd0);
        waitCycles(1);
        checkOutput("run_clk_e7",   {31'd0, oCPU_CLK}, 32'd1);
        checkOutput("run_tick_e7",  {31'd0, oTICK},    32'd1);
        checkOutput("run_cyc_e7",   {16'd0, oCYCLES},  32'd1);
        waitCycles(1);
        checkOutput("run_tick_e8",  {31'd0, oTICK},    32'd0);
        for (int k = 2; k <= 10; k++) begin
            waitCycles(7);
            checkOutput("run_tick_rise", {31'd0, oTICK},   32'd1);
            checkOutput("run_cyc_rise",  {16'd0, oCYCLES}, k);
            waitCycles(1);
        end

        // Edge 80: the 10th high phase began at edge 79. Drop run now; the
        // high phase runs to edge 83 and the stop lands at edge 87.
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            checkOutput("stop_clk",   {31'd0, oCPU_CLK}, (i < 3) ? 32'd1 : 32'd0);
            checkOutput("stop_state", {30'd0, oSTATE},   32'd1);
            waitCycles(1);
        end
        checkOutput("stop_state_final", {30'd0, oSTATE},   32'd0);
        checkOutput("stop_clk_final",   {31'd0, oCPU_CLK}, 32'd0);
        badIdle = 0;
        for (int i = 0; i < 20; i++) begin
            waitCycles(1);
            if (oCPU_CLK !== 1'b0) badIdle++;
        end
        checkOutput("stop_no_runt", badIdle,          32'd0);
        checkOutput("stop_cycles",  {16'd0, oCYCLES}, 32'd10);

        // Bouncy press: press at edge 8, STEP at 9, rise 13, stop at 17
        runPattern(30, 0);
        checkOutput("step1_state_e8",  {30'd0, stObs[8]},   32'd0);
        checkOutput("step1_state_e9",  {30'd0, stObs[9]},   32'd2);
        checkOutput("step1_clk_e12",   {31'd0, clkObs[12]}, 32'd0);
        checkOutput("step1_clk_e13",   {31'd0, clkObs[13]}, 32'd1);
        checkOutput("step1_clk_e16",   {31'd0, clkObs[16]}, 32'd1);
        checkOutput("step1_clk_e17",   {31'd0, clkObs[17]}, 32'd0);
        checkOutput("step1_state_e17", {30'd0, stObs[17]},  32'd0);
        checkOutput("step1_rises",     rises,               32'd1);
        checkOutput("step1_high",      highCycles,          32'd4);
        checkOutput("step1_cycles",    {16'd0, oCYCLES},    32'd11);

        // Clean press (press at 6) plus a second press at 12 while stepping
        runPattern(30, 1);
        checkOutput("step2_state_e6",  {30'd0, stObs[6]},   32'd0);
        checkOutput("step2_state_e7",  {30'd0, stObs[7]},   32'd2);
        checkOutput("step2_clk_e11",   {31'd0, clkObs[11]}, 32'd1);
        checkOutput("step2_state_e15", {30'd0, stObs[15]},  32'd0);
        checkOutput("step2_step_len",  stepCycles,          32'd8);
        checkOutput("step2_rises",     rises,               32'd1);
        checkOutput("step2_high",      highCycles,          32'd4);
        checkOutput("step2_cycles",    {16'd0, oCYCLES},    32'd12);

        // Two-cycle glitch must not become a press
        runPattern(20, 2);
        checkOutput("bounce_step", stepCycles,       32'd0);
        checkOutput("bounce_rise", rises,            32'd0);
        checkOutput("bounce_cyc",  {16'd0, oCYCLES}, 32'd12);

        // run_s and press both first seen at edge 6: RUN wins at edge 7
        runPattern(12, 3);
        checkOutput("prio_state_e6", {30'd0, stObs[6]}, 32'd0);
        checkOutput("prio_state_e7", {30'd0, stObs[7]}, 32'd1);
        checkOutput("prio_no_step",  stepCycles,        32'd0);
        applyStimulus(1'b0, 1'b1);
        waitCycles(30);
        checkOutput("prio_stopped",  {30'd0, oSTATE},   32'd0);
        checkOutput("prio_clk_low",  {31'd0, oCPU_CLK}, 32'd0);

        // Counter wrap: preload 0xFFFE while stopped, then two rises
        @(negedge iCLK);
        force dut.cycles_q = 16'hFFFE;
        #1;
        release dut.cycles_q;
        waitCycles(1);
        checkOutput("wrap_preload", {16'd0, oCYCLES}, 32'h0000FFFE);
        applyStimulus(1'b1, 1'b1);
        waitCycles(6);
        checkOutput("wrap_e6",      {16'd0, oCYCLES}, 32'h0000FFFE);
        waitCycles(1);
        checkOutput("wrap_e7",      {16'd0, oCYCLES}, 32'h0000FFFF);
        checkOutput("wrap_tick_e7", {31'd0, oTICK},   32'd1);
        waitCycles(8);
        checkOutput("wrap_e15",     {16'd0, oCYCLES}, 32'h00000000);
        checkOutput("wrap_tick_e15",{31'd0, oTICK},   32'd1);

        // Asynchronous reset while the clock is high parks everything
        waitCycles(1);
        checkOutput("midrst_pre_clk", {31'd0, oCPU_CLK}, 32'd1);
        #2;
        iRST_N = 1'b0;
        #1;
        checkOutput("midrst_clk",    {31'd0, oCPU_CLK}, 32'd0);
        checkOutput("midrst_state",  {30'd0, oSTATE},   32'd0);
        checkOutput("midrst_cycles", {16'd0, oCYCLES},  32'd0);
        checkOutput("midrst_tick",   {31'd0, oTICK},    32'd0);
        applyStimulus(1'b0, 1'b1);
        waitCycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
